pipeline_flow_controller: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the freeze and flush inputs of the PC, the IF/ID register and the ID/EX register, plus a back-end freeze for the EX/MEM and MEM/WB registers.
- Arbitrates three event sources (memory wait, taken branch, data hazard) with fixed priority.
- Tracks memory-wait time and keeps saturating performance counters.

---
 rtl/pipeline_flow_controller_pkg.sv | 13 +
 rtl/pipeline_flow_controller_sat_counter.sv | 32 +++
 rtl/pipeline_flow_controller.sv | 109 ++++++++++
 tb/tb_pipeline_flow_controller.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_flow_controller_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer:
// FSM state encoding and default sizing.
package pipeline_flow_controller_pkg;

   typedef enum logic {
      STATE_RUN      = 1'b0,
      STATE_MEM_WAIT = 1'b1
   } state_e;

   localparam int TIMEOUT_DEF = 64;
   localparam int CNT_W_DEF   = 16;

endpackage

// File: rtl/pipeline_flow_controller_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_flow_controller.sv
// Central stall/flush sequencer: arbitrates memory wait, taken
// branch and data hazard, and keeps stall/flush statistics.
module pipeline_flow_controller
   import pipeline_flow_controller_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             branch_taken,
   input  logic             hazard,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             freeze_pc,
   output logic             if_freeze,
   output logic             if_flush,
   output logic             id_flush,
   output logic             backend_freeze,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam int WCW = $clog2(TIMEOUT + 1);

   state_e         state_q, state_d;
   logic           pend_q, pend_d;
   logic [WCW-1:0] wcnt_q, wcnt_d;
   logic           tmo_q, tmo_d;
   logic           br;

   assign br = branch_taken | pend_q;

   always_comb begin
      state_d        = state_q;
      pend_d         = pend_q;
      wcnt_d         = wcnt_q;
      tmo_d          = tmo_q;
      freeze_pc      = 1'b0;
      if_freeze      = 1'b0;
      if_flush       = 1'b0;
      id_flush       = 1'b0;
      backend_freeze = 1'b0;
      if (state_q == STATE_RUN && mem_req && !mem_ready) begin
         freeze_pc      = 1'b1;
         if_freeze      = 1'b1;
         backend_freeze = 1'b1;
         state_d        = STATE_MEM_WAIT;
         wcnt_d         = WCW'(1);
         pend_d         = branch_taken;
      end else if (state_q == STATE_MEM_WAIT && !mem_ready) begin
         freeze_pc      = 1'b1;
         if_freeze      = 1'b1;
         backend_freeze = 1'b1;
         pend_d         = pend_q | branch_taken;
         if (wcnt_q == WCW'(TIMEOUT - 1)) begin
            tmo_d = 1'b1;
         end
         if (wcnt_q != WCW'(TIMEOUT)) begin
            wcnt_d = wcnt_q + WCW'(1);
         end
      end else begin
         // RUN decode, also used on the wait release cycle
         if (br) begin
            if_flush = 1'b1;
            id_flush = 1'b1;
         end else if (hazard) begin
            freeze_pc = 1'b1;
            if_freeze = 1'b1;
            id_flush  = 1'b1;
         end
         state_d = STATE_RUN;
         pend_d  = 1'b0;
         wcnt_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= STATE_RUN;
         pend_q  <= 1'b0;
         wcnt_q  <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         wcnt_q  <= wcnt_d;
         tmo_q   <= tmo_d;
      end
   end

   assign mem_timeout = tmo_q;

   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (freeze_pc),
      .count (stall_count)
   );

   sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (if_flush),
      .count (flush_count)
   );

endmodule

// File: tb/tb_pipeline_flow_controller.sv
// Scoreboard bench for pipeline_flow_controller with a small
// cycle model; short TIMEOUT and counter width expose saturation.
module tb_pipeline_flow_controller;

   localparam int TO   = 8;
   localparam int CW   = 4;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst, branch_taken, hazard, mem_req, mem_ready;
   logic          freeze_pc, if_freeze, if_flush, id_flush;
   logic          backend_freeze, mem_timeout;
   logic [CW-1:0] stall_count, flush_count;

   typedef struct {
      logic [4:0] ctl;
      logic       tmo;
      int         sc;
      int         fc;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   bit m_wait = 0;
   bit m_pend = 0;
   bit m_tmo  = 0;
   int m_cnt  = 0;
   int m_stall = 0;
   int m_flush = 0;

   always #5 clk = ~clk;

   pipeline_flow_controller #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk            (clk),
      .rst            (rst),
      .branch_taken   (branch_taken),
      .hazard         (hazard),
      .mem_req        (mem_req),
      .mem_ready      (mem_ready),
      .freeze_pc      (freeze_pc),
      .if_freeze      (if_freeze),
      .if_flush       (if_flush),
      .id_flush       (id_flush),
      .backend_freeze (backend_freeze),
      .mem_timeout    (mem_timeout),
      .stall_count    (stall_count),
      .flush_count    (flush_count)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // ctl = {freeze_pc, if_freeze, if_flush, id_flush, backend_freeze}
   task automatic step(input logic r, input logic b, input logic h,
                       input logic m, input logic y);
      exp_t       e;
      logic [4:0] c;
      bit         brm;
      rst = r; branch_taken = b; hazard = h;
      mem_req = m; mem_ready = y;
      brm = b | m_pend;
      c = 5'b00000;
      if (!m_wait && m && !y) begin
         c = 5'b11001;
         m_wait = 1; m_cnt = 1; m_pend = b;
      end else if (m_wait && !y) begin
         c = 5'b11001;
         m_pend = m_pend | b;
         if (m_cnt == TO - 1) m_tmo = 1;
         if (m_cnt < TO) m_cnt++;
      end else begin
         if (brm) c = 5'b00110;
         else if (h) c = 5'b11010;
         m_wait = 0; m_pend = 0; m_cnt = 0;
      end
      if (c[4] && m_stall < MAXC) m_stall++;
      if (c[2] && m_flush < MAXC) m_flush++;
      if (r) begin
         m_wait = 0; m_pend = 0; m_cnt = 0; m_tmo = 0;
         m_stall = 0; m_flush = 0;
      end
      e.ctl = c; e.tmo = m_tmo; e.sc = m_stall; e.fc = m_flush;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      chk("ctl", 32'({freeze_pc, if_freeze, if_flush, id_flush,
                      backend_freeze}), 32'(e.ctl));
      @(posedge clk);
      #1;
      chk("stall_cnt", 32'(stall_count), 32'(e.sc));
      chk("flush_cnt", 32'(flush_count), 32'(e.fc));
      chk("timeout", 32'(mem_timeout), 32'(e.tmo));
   endtask

   initial begin
      rst = 1'b1; branch_taken = 1'b0; hazard = 1'b0;
      mem_req = 1'b0; mem_ready = 1'b0;
      @(posedge clk);
      #1;
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
      chk("idle_stall", 32'(stall_count), 32'd0);

      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      chk("hz_stall2", 32'(stall_count), 32'd2);

      step(1, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0);
      chk("br_hz_flush", 32'(flush_count), 32'd1);
      chk("br_hz_stall", 32'(stall_count), 32'd0);

      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 1);
      chk("mem_stall3", 32'(stall_count), 32'd3);
      step(0, 0, 0, 1, 0);
      step(0, 0, 1, 1, 1);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1);

      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 1, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 1, 1, 1);
      chk("pend_flush", 32'(flush_count), 32'd1);
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);

      step(1, 0, 0, 0, 0);
      for (int i = 1; i <= 10; i++) begin
         step(0, 0, 0, 1, 0);
         chk("tmo_rise", 32'(mem_timeout), (i >= TO) ? 32'd1 : 32'd0);
      end
      step(0, 0, 0, 1, 1);
      chk("tmo_sticky", 32'(mem_timeout), 32'd1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
      step(1, 0, 0, 1, 0);
      chk("rst_tmo", 32'(mem_timeout), 32'd0);
      chk("rst_stall", 32'(stall_count), 32'd0);
      step(0, 0, 0, 0, 0);

      for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 0);
      chk("stall_sat", 32'(stall_count), 32'(MAXC));
      for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0);
      chk("flush_sat", 32'(flush_count), 32'(MAXC));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
